fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output-side collector for `fft_top`. It captures the FFT's 16-lane output beats while `output_en` is high, undoes the radix-2 bit-reversed bin order, and delivers each 512-point frame in natural bin order over a valid/ready stream. It sits between `fft_top` and the downstream consumer (file dump or magnitude stage). It uses a two-bank ping-pong buffer so one frame can be written while the previous frame is read.

## Interface

Parameters:

- `LANES`, 16: samples per beat.
- `N`, 512: frame length in points. `N/LANES` = 32 beats per frame.
- `DW`, 13: signed sample width, matching the FFT output width.

Ports:

- `clk`  in  1  Rising-edge clock.
- `rstn`  in  1  Reset: asynchronous, active-low.
- `in_valid`  in  1  Driven by `fft_top.output_en`. Qualifies one input beat.
- `in_re`, `in_im`  in  `[DW-1:0]` x `LANES`  Signed input beat, bit-reversed order.
- `out_valid`  out  1  Output beat available.
- `out_ready`  in  1  Consumer accepts the beat.
- `out_re`, `out_im`  out  `[DW-1:0]` x `LANES`  Signed output beat, natural order.
- `out_last`  out  1  High on beat 31 of a frame.
- `overflow`  out  1  Sticky flag: an input beat was dropped.

## Operation

- **Bin mapping.** Input beat `b` (0..31), lane `l` carries bin `bitrev9(b*16+l)`. Output beat `n`, lane `l` carries bin `n*16+l`. Samples pass through bit-exact; there is no arithmetic or width change.
- **Storage.** Two banks, each `N` x complex `DW`. Each bank has a `full` flag.
- **Write side.**
  - Write bank pointer `wb` and beat counter `wcnt` (5 bits).
  - On `in_valid`, if `!full[wb]`: store all 16 lanes at their bit-reversed addresses and increment `wcnt`.
  - On the beat where `wcnt==31`: set `full[wb]`, toggle `wb`, and wrap `wcnt` to 0.
  - Gaps in `in_valid` hold `wcnt`. Partial frames persist until completed.
- **Overflow.** `in_valid` with `full[wb]==1` drops the beat. `wcnt` is unchanged and `overflow` is set to 1. `overflow` is cleared only by reset.
- **Read FSM.** States `IDLE` and `STREAM`, with read bank pointer `rb` and read counter `rcnt`.
  - `IDLE` -> `STREAM` when `full[rb]`. Output register loads beat 0. `rcnt` is 0.
  - In `STREAM`, each handshake (`out_valid && out_ready`) advances `rcnt` and loads the next beat.
  - The handshake with `rcnt==31` (`out_last`) clears `full[rb]` and toggles `rb`. If the other bank is full, the FSM stays in `STREAM` and loads that bank's beat 0 with no bubble. Otherwise it goes to `IDLE`.
- **Simultaneous release and write.** If `full[wb]` is cleared by the last read handshake in the same cycle as `in_valid`, the write is accepted. The bank is free in that cycle.
- **Stall behaviour.** While `out_valid && !out_ready`, `out_re`, `out_im` and `out_last` hold stable.
- **Reset.** Asserting `rstn` low at any point, including mid-frame on either side:
  - clears `full[*]`, `wb`, `rb`, `wcnt`, `rcnt`, and returns the FSM to `IDLE`;
  - forces `out_valid`=0, `out_last`=0, `overflow`=0, `out_re`=`out_im`=0;
  - leaves bank contents undefined; they are never read before being rewritten.

## Timing

- **Latency.** Edge E captures input beat 31 and sets `full`. The FSM enters `STREAM` at edge E+1, and `out_valid` is high after E+1. That is 2 edges from the last input write to the first output beat.
- **Throughput.** With `out_ready` held at 1: one beat per cycle, 32 cycles per frame.
- **Ping-pong headroom.** Back-to-back frames at full input rate never overflow when `out_ready`=1.
- **Registered outputs.** All outputs are registered. There is no combinational path from `in_*` or `out_ready` to any output.

## Test plan

1. **Single-frame reorder.** Input beat b, lane l: `re=bitrev9(b*16+l)`, `im=-re`; 32 contiguous beats; `out_ready`=1.
   Expect: `out_valid` rises 2 edges after the last input beat. Output beat n, lane l: `re=n*16+l`, `im=-(n*16+l)`. Beat 31 lane 15 has `re`=511 with `out_last`=1. `overflow`=0.
2. **Two frames back-to-back.** 64 contiguous beats, `out_ready`=1.
   Expect: 64 consecutive output beats with no bubble between frames, `out_last` at beats 31 and 63, `overflow`=0.
3. **Backpressure overflow.** `out_ready`=0; stream 3 frames.
   Expect: frames 1–2 stored. The first beat of frame 3 is dropped and `overflow`=1 from that edge onward. After raising `out_ready`, frame 1 then frame 2 emerge intact.
4. **Alternating ready.** `out_ready` toggles 1/0 each cycle during frame 1.
   Expect: data and `out_last` stay stable during stalls. The frame completes in 63 cycles with values identical to scenario 1.
5. **Gapped input.** One idle cycle after every input beat.
   Expect: output identical to scenario 1, with first `out_valid` 2 edges after the 32nd accepted beat.
6. **Reset mid-frame.** Assert `rstn`=0 after input beat 10 of frame 1, and again during output beat 5 of another run.
   Expect: all outputs 0 immediately. The next full frame after release reorders correctly, starting at output beat 0.

Source files
------------

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: collects bit-reversed FFT output beats into a two-bank
// ping-pong buffer and streams each frame back out in natural bin order.
module fft_out_reorder #(
   parameter int LANES = 16,
   parameter int N     = 512,
   parameter int DW    = 13
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_valid,
   input  logic [LANES-1:0][DW-1:0] in_re,
   input  logic [LANES-1:0][DW-1:0] in_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES-1:0][DW-1:0] out_re,
   output logic [LANES-1:0][DW-1:0] out_im,
   output logic                     out_last,
   output logic                     overflow
);

   localparam int BEATS = N / LANES;
   localparam int AW    = $clog2(N);
   localparam int BW    = $clog2(BEATS);
   localparam int LW    = $clog2(LANES);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef logic [LANES-1:0][DW-1:0] beat_t;
   typedef enum logic {IDLE, STREAM} state_t;

   // Radix-2 bin order: reverse all AW address bits.
   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      return r;
   endfunction

   // Sample storage: [bank][bin], written at bit-reversed bins, read in natural order.
   logic [DW-1:0] bank_re [2][N];
   logic [DW-1:0] bank_im [2][N];

   state_t        state_q, state_d;
   logic          wb_q, wb_d;
   logic          rb_q, rb_d;
   logic [BW-1:0] wcnt_q, wcnt_d;
   logic [BW-1:0] rcnt_q, rcnt_d;
   logic [1:0]    full_q, full_d;
   logic          overflow_q, overflow_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   beat_t         out_re_q, out_re_d;
   beat_t         out_im_q, out_im_d;

   logic          wr_en;
   logic          rd_release;
   logic          load_en;
   logic          load_bank;
   logic [BW-1:0] load_beat;
   logic [BW-1:0] rcnt_inc;

   // Read FSM: picks which beat the output register loads next.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and a latch is never inferred.
      state_d     = state_q;
      rb_d        = rb_q;
      rcnt_d      = rcnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      rd_release  = 1'b0;
      load_en     = 1'b0;
      load_bank   = rb_q;
      load_beat   = '0;
      rcnt_inc    = rcnt_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (full_q[rb_q]) begin
               state_d     = STREAM;
               load_en     = 1'b1;
               rcnt_d      = '0;
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
            end
         end
         STREAM: begin
            if (out_valid_q && out_ready) begin
               if (rcnt_q == LAST_BEAT) begin
                  rd_release = 1'b1;
                  rb_d       = ~rb_q;
                  rcnt_d     = '0;
                  out_last_d = 1'b0;
                  // Other bank already complete: continue without a bubble.
                  if (full_q[~rb_q]) begin
                     load_en   = 1'b1;
                     load_bank = ~rb_q;
                  end else begin
                     state_d     = IDLE;
                     out_valid_d = 1'b0;
                  end
               end else begin
                  rcnt_d     = rcnt_inc;
                  load_en    = 1'b1;
                  load_beat  = rcnt_inc;
                  out_last_d = (rcnt_inc == LAST_BEAT);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output data register: loads a natural-order beat, otherwise holds (covers stalls).
   always_comb begin
      out_re_d = out_re_q;
      out_im_d = out_im_q;
      if (load_en) begin
         for (int l = 0; l < LANES; l++) begin
            out_re_d[l] = bank_re[load_bank][{load_beat, LW'(l)}];
            out_im_d[l] = bank_im[load_bank][{load_beat, LW'(l)}];
         end
      end
   end

   // Write side. A bank released by this cycle's last read handshake is
   // already free, so a same-cycle input beat into it is accepted.
   always_comb begin
      full_d = full_q;
      if (rd_release) full_d[rb_q] = 1'b0;
      wr_en      = in_valid && !full_d[wb_q];
      overflow_d = overflow_q || (in_valid && full_d[wb_q]);
      wcnt_d     = wcnt_q;
      wb_d       = wb_q;
      if (wr_en) begin
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_q == LAST_BEAT) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its _d value from before the edge, independent of block order.
      if (!rstn) begin
         state_q     <= IDLE;
         wb_q        <= 1'b0;
         rb_q        <= 1'b0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         full_q      <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         state_q     <= state_d;
         wb_q        <= wb_d;
         rb_q        <= rb_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   // NOTE: the sample banks have no reset; a bank is only read after all its
   // bins were rewritten, so clearing it would buy nothing and block RAM mapping.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int l = 0; l < LANES; l++) begin
            bank_re[wb_q][bitrev({wcnt_q, LW'(l)})] <= in_re[l];
            bank_im[wb_q][bitrev({wcnt_q, LW'(l)})] <= in_im[l];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: table of stream scenarios plus
// reset sequences, scored against a frame-level model of the ping-pong buffer.
module tb_fft_out_reorder;

   localparam int LANES = 16;
   localparam int N     = 512;
   localparam int DW    = 13;
   localparam int BEATS = N / LANES;

   typedef logic [LANES-1:0][DW-1:0] beat_t;

   // One scenario: stimulus knobs and the results expected from it (-1 = not checked).
   typedef struct {
      int frames;
      int gap;        // idle cycles after each beat, -1 = random 0..2
      int rdy_mode;   // 0 always, 1 low until input done, 2 alternating, 3 random
      bit rnd_data;
      int exp_beats;
      int exp_ovf;
      int exp_span;   // cycles from first out_valid to last handshake
      int exp_lat;    // negedges from last beat of frame 1 to first out_valid
   } vec_t;

   logic  clk = 1'b0;
   logic  rstn = 1'b0;
   logic  in_valid = 1'b0;
   logic  out_ready = 1'b0;
   beat_t in_re = '0;
   beat_t in_im = '0;
   logic  out_valid, out_last, overflow;
   beat_t out_re, out_im;

   fft_out_reorder #(.LANES(LANES), .N(N), .DW(DW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_re    (in_re),
      .in_im    (in_im),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re   (out_re),
      .out_im   (out_im),
      .out_last (out_last),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: frames held as natural-order sample arrays.
   logic [DW-1:0] src_re [N];
   logic [DW-1:0] src_im [N];
   logic [DW-1:0] fill_re [N];
   logic [DW-1:0] fill_im [N];
   logic [DW-1:0] sb_re [4][N];
   logic [DW-1:0] sb_im [4][N];
   int wbeat, held, sb_wr, sb_rd, rd_beat, frames_done;
   bit ovf_m, stall_pend, in_done, seen_valid;
   beat_t hold_re, hold_im;
   logic  hold_last;
   int cyc, first_valid_cyc, first_done_cyc, last_hs_cyc, hs_count, alt_ph, rdy_mode;

   function automatic int bitrev9(input int a);
      int r = 0;
      int x = a;
      for (int i = 0; i < 9; i++) begin
         r = r * 2 + (x % 2);
         x = x / 2;
      end
      return r;
   endfunction

   task automatic check(input string name, input bit ok, input string detail);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   task automatic clear_model();
      wbeat = 0; held = 0; sb_wr = 0; sb_rd = 0; rd_beat = 0; frames_done = 0;
      ovf_m = 0; stall_pend = 0; in_done = 0; seen_valid = 0;
      cyc = 0; first_valid_cyc = -1; first_done_cyc = -1; last_hs_cyc = -1;
      hs_count = 0; alt_ph = 0;
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic reset_dut(input string name);
      @(negedge clk);
      #1 rstn = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      check(name, out_valid === 1'b0 && out_last === 1'b0 && overflow === 1'b0 &&
                  out_re === '0 && out_im === '0,
            $sformatf("got valid %0b last %0b ovf %0b re0 %0d im0 %0d, want all 0",
                      out_valid, out_last, overflow, out_re[0], out_im[0]));
      clear_model();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // One clock: check outputs, drive inputs, then advance the model over the coming edge.
   task automatic cycle(input bit v, input beat_t re, input beat_t im);
      beat_t exp_re, exp_im;
      bit    rdy, exp_last, found;
      int    bad;
      @(negedge clk);
      cyc++;
      check("overflow", overflow === ovf_m,
            $sformatf("got %0b want %0b at cycle %0d", overflow, ovf_m, cyc));
      if (stall_pend)
         check("stall_hold", out_valid === 1'b1 && out_re === hold_re && out_im === hold_im &&
                             out_last === hold_last,
               $sformatf("got valid %0b last %0b re0 %0d, want valid 1 last %0b re0 %0d",
                         out_valid, out_last, out_re[0], hold_last, hold_re[0]));
      if (out_valid === 1'b1 && !seen_valid) begin
         seen_valid = 1;
         first_valid_cyc = cyc;
      end
      case (rdy_mode)
         0:       rdy = 1'b1;
         1:       rdy = in_done;
         2:       rdy = (alt_ph % 2 == 0);
         default: rdy = ($urandom_range(1, 0) == 1);
      endcase
      in_valid = v;
      in_re = re;
      in_im = im;
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
         check("spurious_beat", held > 0, $sformatf("got out_valid with no stored frame, cycle %0d", cyc));
         if (held > 0) begin
            for (int l = 0; l < LANES; l++) begin
               exp_re[l] = sb_re[sb_rd][rd_beat * LANES + l];
               exp_im[l] = sb_im[sb_rd][rd_beat * LANES + l];
            end
            exp_last = (rd_beat == BEATS - 1);
            bad = 0;
            found = 0;
            for (int l = 0; l < LANES; l++)
               if (!found && (out_re[l] !== exp_re[l] || out_im[l] !== exp_im[l])) begin
                  bad = l;
                  found = 1;
               end
            check("beat_data", out_re === exp_re && out_im === exp_im && out_last === exp_last,
                  $sformatf("beat %0d lane %0d got re %0d im %0d last %0b, want re %0d im %0d last %0b",
                            rd_beat, bad, $signed(out_re[bad]), $signed(out_im[bad]), out_last,
                            $signed(exp_re[bad]), $signed(exp_im[bad]), exp_last));
            hs_count++;
            last_hs_cyc = cyc;
            if (exp_last) begin
               rd_beat = 0;
               sb_rd = (sb_rd + 1) % 4;
               held--;
            end else begin
               rd_beat++;
            end
         end
      end
      stall_pend = (out_valid === 1'b1) && !rdy;
      hold_re = out_re;
      hold_im = out_im;
      hold_last = out_last;
      // Buffer holds at most two completed frames; a third drops beats.
      if (v) begin
         if (held < 2) begin
            for (int l = 0; l < LANES; l++) begin
               fill_re[bitrev9(wbeat * LANES + l)] = re[l];
               fill_im[bitrev9(wbeat * LANES + l)] = im[l];
            end
            wbeat++;
            if (wbeat == BEATS) begin
               for (int i = 0; i < N; i++) begin
                  sb_re[sb_wr][i] = fill_re[i];
                  sb_im[sb_wr][i] = fill_im[i];
               end
               sb_wr = (sb_wr + 1) % 4;
               held++;
               wbeat = 0;
               frames_done++;
               if (frames_done == 1) first_done_cyc = cyc;
            end
         end else begin
            ovf_m = 1;
         end
      end
      if (seen_valid) alt_ph++;
   endtask

   // Sends one frame: natural-order source samples emitted in bit-reversed order.
   task automatic send_frame(input int f, input bit rnd, input int gap);
      beat_t re, im;
      int g;
      for (int i = 0; i < N; i++) begin
         src_re[i] = rnd ? DW'($urandom) : DW'(i + 512 * f);
         src_im[i] = rnd ? DW'($urandom) : -src_re[i];
      end
      for (int b = 0; b < BEATS; b++) begin
         for (int l = 0; l < LANES; l++) begin
            re[l] = src_re[bitrev9(b * LANES + l)];
            im[l] = src_im[bitrev9(b * LANES + l)];
         end
         cycle(1'b1, re, im);
         g = (gap < 0) ? $urandom_range(2, 0) : gap;
         repeat (g) cycle(1'b0, '0, '0);
      end
   endtask

   task automatic drain();
      int budget = 0;
      in_done = 1;
      while (held > 0 && budget < 3000) begin
         cycle(1'b0, '0, '0);
         budget++;
      end
      check("drain", held == 0, $sformatf("got %0d frames still pending after %0d cycles, want 0", held, budget));
      repeat (3) cycle(1'b0, '0, '0);
      check("idle_after", out_valid === 1'b0, $sformatf("got out_valid %0b want 0", out_valid));
   endtask

   task automatic run_vector(input int idx, input vec_t v);
      reset_dut($sformatf("reset_state_v%0d", idx));
      rdy_mode = v.rdy_mode;
      for (int f = 0; f < v.frames; f++) send_frame(f, v.rnd_data, v.gap);
      drain();
      if (v.exp_beats >= 0)
         check("beat_count", hs_count == v.exp_beats,
               $sformatf("vec %0d got %0d beats want %0d", idx, hs_count, v.exp_beats));
      if (v.exp_ovf >= 0)
         check("overflow_final", overflow === v.exp_ovf[0],
               $sformatf("vec %0d got %0b want %0d", idx, overflow, v.exp_ovf));
      if (v.exp_span > 0)
         check("span", last_hs_cyc - first_valid_cyc + 1 == v.exp_span,
               $sformatf("vec %0d got %0d cycles want %0d", idx, last_hs_cyc - first_valid_cyc + 1, v.exp_span));
      check("latency", first_valid_cyc - first_done_cyc == v.exp_lat,
            $sformatf("vec %0d got %0d edges want %0d", idx, first_valid_cyc - first_done_cyc, v.exp_lat));
   endtask

   initial begin
      vec_t vecs[6];
      int   budget;
      clear_model();
      rdy_mode = 0;
      //          frames gap rdy rnd beats ovf span lat
      vecs[0] = '{1,     0,  0,  0,  32,   0,  32,  2};  // single frame
      vecs[1] = '{2,     0,  0,  0,  64,   0,  64,  2};  // back-to-back, no bubble
      vecs[2] = '{3,     0,  1,  0,  64,   1,  -1,  2};  // backpressure overflow
      vecs[3] = '{1,     0,  2,  0,  32,   0,  63,  2};  // alternating ready
      vecs[4] = '{1,     1,  0,  0,  32,   0,  32,  2};  // gapped input
      vecs[5] = '{6,    -1,  3,  1,  -1,  -1,  -1,  2};  // random data, gaps, ready

      for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

      // Reset during input: partial frame discarded, next frame starts clean.
      reset_dut("reset_state_a");
      rdy_mode = 0;
      for (int b = 0; b <= 10; b++) begin
         beat_t re;
         for (int l = 0; l < LANES; l++) re[l] = DW'(100 + b);
         cycle(1'b1, re, ~re);
      end
      reset_dut("reset_mid_input");
      send_frame(0, 1'b0, 0);
      drain();
      check("after_in_reset", hs_count == 32, $sformatf("got %0d beats want 32", hs_count));

      // Reset during output streaming.
      reset_dut("reset_state_b");
      rdy_mode = 0;
      send_frame(1, 1'b0, 0);
      budget = 0;
      while (hs_count < 5 && budget < 100) begin
         cycle(1'b0, '0, '0);
         budget++;
      end
      check("reach_out_beat5", hs_count == 5, $sformatf("got %0d beats want 5", hs_count));
      reset_dut("reset_mid_output");
      send_frame(2, 1'b0, 0);
      drain();
      check("after_out_reset", hs_count == 32, $sformatf("got %0d beats want 32", hs_count));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
